// File: rtl/dffrsnq_pipe_pkg.sv
// Shared types and elaboration helpers for the dffrsnq_pipe pipeline register.
package dffrsnq_pipe_pkg;

    typedef enum logic [1:0] {
        STAGE_HOLD  = 2'd0,
        STAGE_LOAD  = 2'd1,
        STAGE_FLUSH = 2'd2,
        STAGE_SCAN  = 2'd3
    } stage_mode_e;

    // Number of flops visited by the scan chain: one valid bit plus WIDTH data bits per stage.
    function automatic int scan_len(input int width, input int depth);
        return depth * (width + 1);
    endfunction

    function automatic bit params_legal(input int width, input int depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/dffrsnq_pipe_stage.sv
// One pipeline stage: a valid flop plus WIDTH data flops with per-bit reset value and scan.
module dffrsnq_pipe_stage
    import dffrsnq_pipe_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rn_i,
    input  logic             scan_en_i,
    input  logic             scan_i,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             scan_o
);

    stage_mode_e      mode;
    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   chain;

    // Scan order inside a stage runs valid bit first, then data bit 0 up to bit WIDTH-1.
    assign chain = {r_q, v_q};

    always_comb begin
        mode = STAGE_HOLD;
        if (scan_en_i) begin
            mode = STAGE_SCAN;
        end else if (flush_i) begin
            mode = STAGE_FLUSH;
        end else if (load_i) begin
            mode = STAGE_LOAD;
        end
    end

    // Data flops only toggle when a valid word arrives, so bubbles leave them quiet.
    always_comb begin
        v_d = v_q;
        r_d = r_q;
        case (mode)
            STAGE_SCAN: begin
                v_d = scan_i;
                r_d = chain[WIDTH-1:0];
            end
            STAGE_FLUSH: begin
                v_d = 1'b0;
            end
            STAGE_LOAD: begin
                v_d = valid_i;
                if (valid_i) begin
                    r_d = data_i;
                end
            end
            default: begin
                v_d = v_q;
                r_d = r_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            v_q <= 1'b0;
            r_q <= INIT;
        end else begin
            v_q <= v_d;
            r_q <= r_d;
        end
    end

    assign valid_o = v_q;
    assign data_o  = r_q;
    assign scan_o  = r_q[WIDTH-1];

endmodule

// File: rtl/dffrsnq_pipe.sv
// Parametrised valid/ready pipeline register built from DEPTH scan-capable stages.
module dffrsnq_pipe
    import dffrsnq_pipe_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q
);

    if (!params_legal(WIDTH, DEPTH)) begin : g_bad_params
        $error("dffrsnq_pipe: WIDTH and DEPTH must both be at least 1");
    end

    logic [DEPTH-1:0] stage_v;
    logic [WIDTH-1:0] stage_r [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH:0]   scan_chain;

    // A stage can load when it is empty or when everything downstream of it moves this cycle.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~stage_v[i] | rdy[i+1];
        end
    end

    assign IN_READY      = rdy[0] & ~SE & ~FLUSH;
    assign OUT_VALID     = stage_v[DEPTH-1] & ~SE;
    assign Q             = stage_r[DEPTH-1];
    assign scan_chain[0] = SI;

    // SO is quiet outside scan so a set-type last bit does not leak onto the scan net.
    assign SO = SE & scan_chain[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             in_valid;
        logic [WIDTH-1:0] in_data;

        if (i == 0) begin : g_head
            assign in_valid = IN_VALID & IN_READY;
            assign in_data  = D;
        end else begin : g_body
            assign in_valid = stage_v[i-1];
            assign in_data  = stage_r[i-1];
        end

        dffrsnq_pipe_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk_i     (CLK),
            .rn_i      (RN),
            .scan_en_i (SE),
            .scan_i    (scan_chain[i]),
            .load_i    (rdy[i]),
            .flush_i   (FLUSH),
            .valid_i   (in_valid),
            .data_i    (in_data),
            .valid_o   (stage_v[i]),
            .data_o    (stage_r[i]),
            .scan_o    (scan_chain[i+1])
        );
    end

endmodule

// File: tb/tb_dffrsnq_pipe.sv
// Scoreboard bench for dffrsnq_pipe (WIDTH=8, DEPTH=3, INIT=8'hA5) with random and directed traffic.
module tb_dffrsnq_pipe;

    localparam int               Width    = 8;
    localparam int               Depth    = 3;
    localparam logic [Width-1:0] Init     = 8'hA5;
    localparam int               ChainLen = Depth * (Width + 1);

    logic             CLK = 1'b0;
    logic             RN = 1'b1;
    logic             SE = 1'b0;
    logic             SI = 1'b0;
    logic             SO;
    logic             FLUSH = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [Width-1:0] D = '0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [Width-1:0] Q;

    logic [Width-1:0] expq[$];
    bit               flushPending = 1'b0;
    int               checkCount = 0;
    int               errorCount = 0;

    dffrsnq_pipe #(
        .WIDTH (Width),
        .DEPTH (Depth),
        .INIT  (Init)
    ) dut (
        .CLK       (CLK),
        .RN        (RN),
        .SE        (SE),
        .SI        (SI),
        .SO        (SO),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .D         (D),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Q         (Q)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Output side: every transfer the DUT offers must match the oldest accepted word.
    always @(negedge CLK) begin
        if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            if (expq.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL spurious output: got Q=%0h, expected no transfer (t=%0t)", Q, $time);
            end else begin
                checkOutput("scoreboard Q", Q, expq.pop_front());
            end
        end
    end

    // One functional cycle: inputs change 1 after the edge, sampling happens 1 later.
    task automatic applyStimulus(input logic inValid, input logic [Width-1:0] data,
                                 input logic outReady, input logic flush, output bit accepted);
        logic expReady;
        @(posedge CLK);
        if (flushPending) begin
            expq.delete();
            flushPending = 1'b0;
        end
        #1;
        SE        = 1'b0;
        IN_VALID  = inValid;
        D         = data;
        OUT_READY = outReady;
        FLUSH     = flush;
        #1;
        expReady = !flush && ((expq.size() < Depth) || outReady);
        checkOutput("IN_READY", IN_READY, expReady);
        accepted = (IN_VALID && IN_READY);
        if (accepted) expq.push_back(data);
        if (flush) flushPending = 1'b1;
    endtask

    task automatic applyReset(input int holdCycles);
        @(posedge CLK);
        #1;
        RN        = 1'b0;
        SE        = 1'b0;
        SI        = 1'b0;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        D         = '0;
        expq.delete();
        flushPending = 1'b0;
        #1;
        checkOutput("reset OUT_VALID", OUT_VALID, 0);
        checkOutput("reset Q", Q, Init);
        checkOutput("reset IN_READY", IN_READY, 1);
        checkOutput("reset SO", SO, 0);
        repeat (holdCycles) @(posedge CLK);
        #1;
        RN = 1'b1;
    endtask

    task automatic drain();
        bit acc;
        int c = 0;
        do begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
            c++;
        end while (expq.size() != 0 && c < 20);
        checkOutput("drain leftover words", expq.size(), 0);
        checkOutput("drain OUT_VALID", OUT_VALID, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   acc;
        int   nextItem;
        int   accepts;
        logic siBits[ChainLen];
        logic soSeq[$];

        // Reset and first cycle after release.
        applyReset(2);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        checkOutput("post-reset Q", Q, Init);
        checkOutput("post-reset OUT_VALID", OUT_VALID, 0);

        // Reset in the middle of traffic drops OUT_VALID at once.
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h6B, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        checkOutput("mid-stream OUT_VALID", OUT_VALID, 1);
        checkOutput("mid-stream Q", Q, 8'h5A);
        applyReset(1);

        // Streaming latency: output rises DEPTH cycles after the first accept, one word per cycle.
        for (int c = 0; c < 9; c++) begin
            applyStimulus(c < 4, 8'(c + 1), 1'b1, 1'b0, acc);
            checkOutput("latency OUT_VALID", OUT_VALID, (c >= 3 && c <= 6));
        end
        drain();

        // Backpressure: exactly DEPTH words fit, the rest wait and follow in order.
        applyReset(1);
        nextItem = 1;
        accepts  = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 8'(nextItem), 1'b0, 1'b0, acc);
            if (acc) begin
                nextItem++;
                accepts++;
            end
        end
        checkOutput("backpressure accepts", accepts, 3);
        checkOutput("full IN_READY", IN_READY, 0);
        for (int c = 0; c < 20 && nextItem <= 5; c++) begin
            applyStimulus(1'b1, 8'(nextItem), 1'b1, 1'b0, acc);
            if (acc) nextItem++;
        end
        checkOutput("all words accepted", nextItem, 6);
        drain();

        // Flush with a bubble: last word still delivered, everything else dropped, data flops kept.
        applyReset(1);
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b1, acc);
        checkOutput("flush-cycle OUT_VALID", OUT_VALID, 1);
        checkOutput("flush-cycle Q", Q, 8'h11);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        checkOutput("after flush OUT_VALID", OUT_VALID, 0);
        checkOutput("after flush Q kept", Q, 8'h11);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        checkOutput("after flush still empty", OUT_VALID, 0);

        // Single word with a stalling consumer: held while refused, sent exactly once.
        applyReset(1);
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, acc);
        checkOutput("3C accepted", acc, 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        checkOutput("3C held OUT_VALID", OUT_VALID, 1);
        checkOutput("3C held Q", Q, 8'h3C);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        checkOutput("3C offered OUT_VALID", OUT_VALID, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        checkOutput("3C gone OUT_VALID", OUT_VALID, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        checkOutput("3C no duplicate", OUT_VALID, 0);
        checkOutput("3C delivered", expq.size(), 0);

        // Random traffic with occasional flushes.
        applyReset(1);
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0), acc);
        end
        drain();

        // Scan: first the reset contents come out, then the shifted-in pattern replays.
        applyReset(1);
        for (int s = 0; s < Depth; s++) begin
            for (int b = Width - 1; b >= 0; b--) soSeq.push_back(Init[b]);
            soSeq.push_back(1'b0);
        end
        for (int k = 0; k < ChainLen; k++) begin
            siBits[k] = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : (k < 4) ? 1'b1 : 1'($urandom);
            soSeq.push_back(siBits[k]);
        end
        for (int k = 0; k < 2 * ChainLen; k++) begin
            @(posedge CLK);
            #1;
            SE        = 1'b1;
            SI        = (k < ChainLen) ? siBits[k] : 1'($urandom);
            IN_VALID  = 1'b1;
            OUT_READY = 1'b1;
            FLUSH     = k[0];
            #1;
            checkOutput("scan SO", SO, soSeq[k]);
            checkOutput("scan OUT_VALID", OUT_VALID, 0);
            checkOutput("scan IN_READY", IN_READY, 0);
        end
        applyReset(1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
